// File: rtl/pp_package.sv
// Packet-path shared types: stream widths and serializer word/state types.
package pp_package;

  localparam int TDATA_WIDTH = 32;
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int SER_DEPTH   = 4;
  localparam int SER_CNT_W   = $clog2(SER_DEPTH + 1);

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

  typedef struct packed {
    logic [TDATA_WIDTH*SER_DEPTH-1:0] data;
    logic [SER_CNT_W-1:0]             beats;
    logic                             last;
    logic [TKEEP_WIDTH-1:0]           keep;
  } ser_word_t;

endpackage

// File: rtl/beat_serializer.sv
// Wide word to AXI4-Stream beat serializer, lowest slice first.
// Optional BEAT_SER_PREFETCH_EN adds a holding register for bubble-free words.
module beat_serializer
  import pp_package::*;
#(
  parameter int DEPTH = SER_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TDATA_WIDTH*DEPTH-1:0] in_data,
  input  logic [$clog2(DEPTH+1)-1:0]   in_beats,
  input  logic                         in_last,
  input  logic [TKEEP_WIDTH-1:0]       in_keep,
  output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [TKEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                         busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ser_state_t state, nxt_state;
  ser_word_t  cur, nxt_cur, word_in;
  logic [CNT_W-1:0] idx, nxt_idx;
  logic acc, fire, final_beat, hold_vld;
  logic nxt_last;

  always_comb begin
    word_in       = '0;
    word_in.data  = in_data;
    word_in.beats = in_beats;
    if (in_beats == '0 || int'(in_beats) > DEPTH)
      word_in.beats = CNT_W'(DEPTH);
    word_in.last  = in_last;
    word_in.keep  = in_keep;
  end

  assign acc        = in_valid & in_ready;
  assign fire       = (state == SER_SEND) & m_axis_tready;
  assign final_beat = (idx == cur.beats - CNT_W'(1));
  assign m_axis_tvalid = (state == SER_SEND);

`ifdef BEAT_SER_PREFETCH_EN
  ser_word_t hold, nxt_hold;
  logic      nxt_hvld;

  assign in_ready = ~hold_vld;

  // A word arriving on the final-beat edge bypasses the holding register.
  always_comb begin
    nxt_hold = hold;
    nxt_hvld = hold_vld;
    if (fire && final_beat && hold_vld)
      nxt_hvld = 1'b0;
    if (acc && state == SER_SEND && !(fire && final_beat)) begin
      nxt_hold = word_in;
      nxt_hvld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else begin
      hold     <= nxt_hold;
      hold_vld <= nxt_hvld;
    end
  end
`else
  assign hold_vld = 1'b0;
  assign in_ready = (state == SER_IDLE);
`endif

  assign busy = (state != SER_IDLE) | hold_vld;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cur   = cur;
    unique case (state)
      SER_IDLE: begin
        if (acc) begin
          nxt_cur   = word_in;
          nxt_idx   = '0;
          nxt_state = SER_SEND;
        end
      end
      SER_SEND: begin
        if (fire) begin
          if (!final_beat) begin
            nxt_idx = idx + CNT_W'(1);
          end else begin
`ifdef BEAT_SER_PREFETCH_EN
            if (hold_vld) begin
              nxt_cur = hold;
              nxt_idx = '0;
            end else if (acc) begin
              nxt_cur = word_in;
              nxt_idx = '0;
            end else begin
              nxt_state = SER_IDLE;
            end
`else
            nxt_state = SER_IDLE;
`endif
          end
        end
      end
      default: nxt_state = SER_IDLE;
    endcase
  end

  // Output beat is computed from the next word/index so it is registered.
  assign nxt_last = nxt_cur.last && (nxt_idx == nxt_cur.beats - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SER_IDLE;
      idx          <= '0;
      cur          <= '0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tkeep <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      cur   <= nxt_cur;
      if (nxt_state == SER_SEND) begin
        m_axis_tdata <= nxt_cur.data[int'(nxt_idx)*TDATA_WIDTH +: TDATA_WIDTH];
        m_axis_tlast <= nxt_last;
        m_axis_tkeep <= nxt_last ? nxt_cur.keep : '1;
      end else begin
        m_axis_tdata <= '0;
        m_axis_tlast <= 1'b0;
        m_axis_tkeep <= '0;
      end
    end
  end

endmodule

// File: tb/tb_beat_serializer.sv
// Directed self-checking bench for beat_serializer (DEPTH=4, 32-bit beats).
module tb_beat_serializer;
  import pp_package::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [2:0]   in_beats;
  logic         in_last;
  logic [3:0]   in_keep;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [3:0]   m_axis_tkeep;
  logic         busy;

  int nchk = 0;
  int nerr = 0;

  beat_serializer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_beats(in_beats),
    .in_last(in_last), .in_keep(in_keep),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] d,
                      input logic l, input logic [3:0] k);
    chk({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd1);
    chk({tag, ".tdata"}, 64'(m_axis_tdata), 64'(d));
    chk({tag, ".tlast"}, 64'(m_axis_tlast), 64'(l));
    chk({tag, ".tkeep"}, 64'(m_axis_tkeep), 64'(k));
    step();
  endtask

  task automatic put(input logic [127:0] d, input logic [2:0] b,
                     input logic l, input logic [3:0] k);
    logic r;
    in_valid = 1'b1;
    in_data  = d;
    in_beats = b;
    in_last  = l;
    in_keep  = k;
    for (int i = 0; i < 50; i++) begin
      r = in_ready;
      step();
      if (r) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("put_timeout", 64'd0, 64'd1);
  endtask

  localparam logic [127:0] D1 =
    {32'h44443333, 32'h33332222, 32'h22221111, 32'h11110000};
  localparam logic [127:0] D2 =
    {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] D3 =
    {32'h90000004, 32'h80000003, 32'h70000002, 32'h60000001};
  localparam logic [127:0] D4 =
    {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h5A5A5A5A, 32'hA5A5A5A5};
  localparam logic [127:0] D5 =
    {32'hEEEE0004, 32'hEEEE0003, 32'hEEEE0002, 32'hCAFEF00D};
  localparam logic [127:0] DA =
    {32'h0000A004, 32'h0000A003, 32'h0000A002, 32'h0000A001};
  localparam logic [127:0] DB =
    {32'h0000B004, 32'h0000B003, 32'h0000B002, 32'h0000B001};

  initial begin
    logic [127:0] w;
    logic [31:0]  got [8];
    bit           rdy_pat [8];
    int hs, first, lastc, acc;
    logic r;

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_beats = '0;
    in_last = 1'b0;
    in_keep = '0;
    m_axis_tready = 1'b1;
    step();
    step();
    chk("rst.tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst.tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst.tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst.tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // Single full word
    put(D1, 3'd4, 1'b1, 4'h3);
    chk("w1.busy", 64'(busy), 64'd1);
    beat("w1.b0", 32'h11110000, 1'b0, 4'hF);
    beat("w1.b1", 32'h22221111, 1'b0, 4'hF);
    beat("w1.b2", 32'h33332222, 1'b0, 4'hF);
    beat("w1.b3", 32'h44443333, 1'b1, 4'h3);
    chk("w1.end_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("w1.end_in_ready", 64'(in_ready), 64'd1);

    // Backpressure
    rdy_pat = '{1, 0, 0, 1, 1, 0, 1, 1};
    w = D2;
    put(D2, 3'd4, 1'b1, 4'h7);
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      if (hs < 4) begin
        m_axis_tready = rdy_pat[c];
        chk("bp.tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("bp.tdata", 64'(m_axis_tdata), 64'(w[hs*32 +: 32]));
        chk("bp.tlast", 64'(m_axis_tlast), 64'(hs == 3));
        chk("bp.tkeep", 64'(m_axis_tkeep), (hs == 3) ? 64'h7 : 64'hF);
        if (m_axis_tvalid && m_axis_tready) hs++;
        step();
      end
    end
    m_axis_tready = 1'b1;
    chk("bp.handshakes", 64'(hs), 64'd4);
    chk("bp.end_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Short word, not last
    put(D3, 3'd2, 1'b0, 4'h1);
    beat("sh.b0", 32'h60000001, 1'b0, 4'hF);
    beat("sh.b1", 32'h70000002, 1'b0, 4'hF);
    chk("sh.end_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Count clamping
    put(D4, 3'd0, 1'b1, 4'h1);
    beat("c0.b0", 32'hA5A5A5A5, 1'b0, 4'hF);
    beat("c0.b1", 32'h5A5A5A5A, 1'b0, 4'hF);
    beat("c0.b2", 32'hF0F0F0F0, 1'b0, 4'hF);
    beat("c0.b3", 32'h0F0F0F0F, 1'b1, 4'h1);
    chk("c0.end_tvalid", 64'(m_axis_tvalid), 64'd0);
    put(D1, 3'd7, 1'b1, 4'h3);
    beat("c7.b0", 32'h11110000, 1'b0, 4'hF);
    beat("c7.b1", 32'h22221111, 1'b0, 4'hF);
    beat("c7.b2", 32'h33332222, 1'b0, 4'hF);
    beat("c7.b3", 32'h44443333, 1'b1, 4'h3);
    chk("c7.end_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Reset mid-word
    put(D2, 3'd4, 1'b1, 4'hF);
    beat("rm.b0", 32'hAAAA0000, 1'b0, 4'hF);
    beat("rm.b1", 32'hBBBB0001, 1'b0, 4'hF);
    rst = 1'b0;
    step();
    chk("rm.tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rm.busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();
    chk("rm.tvalid_idle", 64'(m_axis_tvalid), 64'd0);
    put(D5, 3'd1, 1'b1, 4'h5);
    beat("rm.single", 32'hCAFEF00D, 1'b1, 4'h5);
    chk("rm.end_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Back-to-back 3-beat words
    in_valid = 1'b1;
    in_data  = DA;
    in_beats = 3'd3;
    in_last  = 1'b1;
    in_keep  = 4'hF;
    acc = 0;
    hs = 0;
    first = -1;
    lastc = -1;
    for (int c = 0; c < 20; c++) begin
      r = in_valid & in_ready;
      if (m_axis_tvalid) begin
        if (hs < 8) got[hs] = m_axis_tdata;
        hs++;
        if (first < 0) first = c;
        lastc = c;
      end
      step();
      if (r) begin
        acc++;
        if (acc == 1) in_data = DB;
        if (acc == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b.accepts", 64'(acc), 64'd2);
    chk("b2b.valid_cycles", 64'(hs), 64'd6);
`ifdef BEAT_SER_PREFETCH_EN
    chk("b2b.span", 64'(lastc - first + 1), 64'd6);
`else
    chk("b2b.span", 64'(lastc - first + 1), 64'd7);
`endif
    chk("b2b.d0", 64'(got[0]), 64'h0000A001);
    chk("b2b.d2", 64'(got[2]), 64'h0000A003);
    chk("b2b.d3", 64'(got[3]), 64'h0000B001);
    chk("b2b.d5", 64'(got[5]), 64'h0000B003);
    chk("b2b.busy_end", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
